// File: rtl/syst_dft_bank.sv
// syst_dft_bank: multi-bin systolic DFT accumulator.
// Accumulates NUM_BINS complex dot products of a real sample frame against
// static twiddles and serialises each finished frame one bin per handshake
// while the next frame keeps accumulating.
// Optional macro SYST_DFT_SAT_EN: every accumulator add saturates instead of wrapping.
module syst_dft_bank #(
   parameter int W_WIDTH      = 16,
   parameter int X_WIDTH      = 16,
   parameter int S_WIDTH      = 32,
   parameter int FRAME_LENGTH = 4,
   parameter int NUM_BINS     = 2,
   localparam int BW          = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     enable,
   input  logic [NUM_BINS*FRAME_LENGTH*W_WIDTH-1:0] w_re,
   input  logic [NUM_BINS*FRAME_LENGTH*W_WIDTH-1:0] w_im,
   input  logic signed [X_WIDTH-1:0]                x,
   input  logic                                     x_valid,
   input  logic                                     x_sof,
   output logic                                     x_ready,
   output logic signed [S_WIDTH-1:0]                re,
   output logic signed [S_WIDTH-1:0]                im,
   output logic [BW-1:0]                            bin_idx,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     out_last,
   output logic                                     frame_err
);

   localparam int PW = $clog2(FRAME_LENGTH);
   localparam int PX = W_WIDTH + X_WIDTH;
   localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LENGTH - 1);
   localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [PW-1:0]              pos_q, pos_d;
   logic [BW-1:0]              bin_q, bin_d;
   logic                       frame_err_q, frame_err_d;
   logic signed [S_WIDTH-1:0]  acc_re_q [NUM_BINS];
   logic signed [S_WIDTH-1:0]  acc_im_q [NUM_BINS];
   logic signed [S_WIDTH-1:0]  acc_re_d [NUM_BINS];
   logic signed [S_WIDTH-1:0]  acc_im_d [NUM_BINS];
   logic signed [S_WIDTH-1:0]  res_re_q [NUM_BINS];
   logic signed [S_WIDTH-1:0]  res_im_q [NUM_BINS];
   logic signed [S_WIDTH-1:0]  res_re_d [NUM_BINS];
   logic signed [S_WIDTH-1:0]  res_im_d [NUM_BINS];
   logic signed [S_WIDTH-1:0]  prod_re  [NUM_BINS];
   logic signed [S_WIDTH-1:0]  prod_im  [NUM_BINS];

   logic          accept, frame_end, handshake, drain_done, res_full;
   logic [PW-1:0] k;

   function automatic logic signed [S_WIDTH-1:0] acc_add(
      input logic signed [S_WIDTH-1:0] a,
      input logic signed [S_WIDTH-1:0] b
   );
      logic signed [S_WIDTH-1:0] s;
      s = a + b;
`ifdef SYST_DFT_SAT_EN
      if ((a[S_WIDTH-1] == b[S_WIDTH-1]) && (s[S_WIDTH-1] != a[S_WIDTH-1]))
         s = a[S_WIDTH-1] ? {1'b1, {(S_WIDTH-1){1'b0}}} : {1'b0, {(S_WIDTH-1){1'b1}}};
`endif
      return s;
   endfunction

   // A finished frame is held exactly while the drain FSM is in DRAIN, so the
   // result-full flag is the state itself rather than a separate register.
   assign res_full   = (state_q == DRAIN);
   assign out_valid  = res_full;
   assign out_last   = out_valid & (bin_q == LAST_BIN);
   assign bin_idx    = bin_q;
   assign re         = out_valid ? res_re_q[bin_q] : '0;
   assign im         = out_valid ? res_im_q[bin_q] : '0;
   assign frame_err  = frame_err_q;
   assign handshake  = out_valid & out_ready;
   assign drain_done = handshake & out_last;
   assign x_ready    = enable & ((pos_q != LAST_POS) | ~res_full | drain_done);
   assign accept     = x_valid & x_ready;
   assign k          = x_sof ? '0 : pos_q;
   assign frame_end  = accept & (k == LAST_POS);

   // Full-precision twiddle * sample products at the effective frame position
   always_comb begin
      logic signed [W_WIDTH-1:0] wr, wi;
      logic signed [PX-1:0]      pr, pi;
      int unsigned               widx;
      for (int unsigned b = 0; b < NUM_BINS; b++) begin
         widx       = (b * FRAME_LENGTH + int'(k)) * W_WIDTH;
         wr         = w_re[widx +: W_WIDTH];
         wi         = w_im[widx +: W_WIDTH];
         pr         = PX'(wr) * PX'(x);
         pi         = PX'(wi) * PX'(x);
         prod_re[b] = S_WIDTH'(pr);
         prod_im[b] = S_WIDTH'(pi);
      end
   end

   // Accumulator, result bank, frame position and resync error next-state
   always_comb begin
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;
      pos_d       = pos_q;
      frame_err_d = accept & x_sof & (pos_q != '0);
      if (accept) begin
         for (int unsigned b = 0; b < NUM_BINS; b++) begin
            if (frame_end) begin
               res_re_d[b] = acc_add(acc_re_q[b], prod_re[b]);
               res_im_d[b] = acc_add(acc_im_q[b], prod_im[b]);
               acc_re_d[b] = '0;
               acc_im_d[b] = '0;
            end else begin
               acc_re_d[b] = acc_add(x_sof ? '0 : acc_re_q[b], prod_re[b]);
               acc_im_d[b] = acc_add(x_sof ? '0 : acc_im_q[b], prod_im[b]);
            end
         end
         pos_d = frame_end ? '0 : k + PW'(1);
      end
   end

   // Drain FSM: a frame end arriving on the last-bin handshake restarts at bin 0
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      unique case (state_q)
         IDLE: begin
            if (frame_end) begin
               state_d = DRAIN;
               bin_d   = '0;
            end
         end
         DRAIN: begin
            if (handshake) begin
               if (out_last) begin
                  bin_d   = '0;
                  state_d = frame_end ? DRAIN : IDLE;
               end else begin
                  bin_d = bin_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset discarding partial and held results
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pos_q       <= '0;
         bin_q       <= '0;
         frame_err_q <= 1'b0;
         acc_re_q    <= '{default: '0};
         acc_im_q    <= '{default: '0};
         res_re_q    <= '{default: '0};
         res_im_q    <= '{default: '0};
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         bin_q       <= bin_d;
         frame_err_q <= frame_err_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         res_re_q    <= res_re_d;
         res_im_q    <= res_im_d;
      end
   end

endmodule

// File: doc/syst_dft_bank.md
Name: syst_dft_bank

Overview:
- Multi-bin successor to the single-bin systolic DFT accumulator in the fft path.
- Accepts a stream of real samples, one frame position per accepted sample, and accumulates NUM_BINS complex dot products in parallel against static twiddle weights.
- Finished bins are serialised one per handshake, while accumulation of the next frame continues.
- Sits between the sample framer and the magnitude/peak stage.

Parameters:
- W_WIDTH, 16: signed twiddle width (re and im).
- X_WIDTH, 16: signed sample width.
- S_WIDTH, 32: signed accumulator/output width; must be >= W_WIDTH+X_WIDTH.
- FRAME_LENGTH, 4: samples per frame; must be >= 2.
- NUM_BINS, 2: bins computed concurrently; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  input-side run enable.
- w_re  in  NUM_BINS*FRAME_LENGTH*W_WIDTH  twiddle real parts; element [b][k] at bits (b*FRAME_LENGTH+k)*W_WIDTH +: W_WIDTH. Static during operation.
- w_im  in  NUM_BINS*FRAME_LENGTH*W_WIDTH  twiddle imaginary parts; same packing as w_re.
- x  in  X_WIDTH  signed sample.
- x_valid  in  1  sample present.
- x_sof  in  1  start-of-frame marker; qualified by x_valid.
- x_ready  out  1  sample accepted this cycle when x_valid & x_ready.
- re  out  S_WIDTH  signed real part of the current output bin.
- im  out  S_WIDTH  signed imaginary part of the current output bin.
- bin_idx  out  max(1,$clog2(NUM_BINS))  index of the bin on re/im.
- out_valid  out  1  re/im/bin_idx valid.
- out_ready  in  1  downstream accepts the bin.
- out_last  out  1  high with out_valid when bin_idx == NUM_BINS-1.
- frame_err  out  1  one-cycle pulse on frame resync.

Behaviour:
- Reset: pos=0, all acc_re/acc_im=0, res_full=0, bin_idx=0, out_valid=0, out_last=0, frame_err=0, re=im=0. Reset mid-frame or mid-drain discards all partial and held results.
- Accept = x_valid & x_ready.
- Effective position k = 0 if x_sof is set, else pos.
- Product: w_re[b][k]*x and w_im[b][k]*x in full W_WIDTH+X_WIDTH signed precision, sign-extended to S_WIDTH. Additions wrap modulo 2^S_WIDTH.
- Accept with k < FRAME_LENGTH-1:
  - acc[b] <= (x_sof ? 0 : acc[b]) + product, for every b.
  - pos <= k+1.
- Accept with k == FRAME_LENGTH-1:
  - res[b] <= acc[b] + product; acc <= 0; pos <= 0; res_full <= 1.
- x_sof accepted while pos != 0: partial frame dropped, acc restarts from this sample, frame_err pulses on the next cycle. x_sof with pos == 0 is normal and gives no error.
- x_ready = enable & (pos != FRAME_LENGTH-1 | ~res_full | drain_done), where drain_done = out_valid & out_ready & out_last. This is a combinational path from out_ready by design.
- x_sof overrides the position: if x_sof arrives at pos == FRAME_LENGTH-1, k=0 and it is not a frame end. x_ready still follows the rule above.
- enable=0 forces x_ready=0, so acc and pos hold. The output drain is unaffected by enable.
- Output FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN on the cycle after res_full rises. out_valid=1, bin_idx=0. Latency is 1 cycle from the last-sample accept to the first out_valid.
  - In DRAIN, re/im = res[bin_idx].
  - Handshake with bin_idx < NUM_BINS-1: bin_idx++.
  - Handshake with out_last: res_full <= 0 and bin_idx <= 0.
  - If a new frame end is accepted in that same cycle, res is overwritten, res_full stays 1, and the FSM stays in DRAIN starting at bin 0. Otherwise DRAIN -> IDLE with out_valid=0.
- While out_valid=1 and out_ready=0, re/im/bin_idx/out_last must hold stable.
- NUM_BINS=1: out_last is constantly high whenever out_valid is high.

Optional Feature:
- Macro SYST_DFT_SAT_EN.
- Defined: every accumulator add (including the final res add) saturates to [-2^(S_WIDTH-1), 2^(S_WIDTH-1)-1] on signed overflow. Each add saturates independently, so there is no sticky clamp.
- Undefined: two's-complement wrap as described in Behaviour. No saturation logic is present.

Test Plan:
Common setup for all tests: defaults, bin0 w_re={2,3,4,5}, w_im={1,-2,-3,4}; bin1 w_re={1,1,1,1}, w_im={0,0,0,0}.
- Basic frame: x=1,2,3,4 back-to-back, x_sof on the first sample, out_ready=1 -> bin0 (40,4) with bin_idx=0, then bin1 (10,0) with out_last=1. First out_valid occurs 1 cycle after the 4th accept.
- Enable stall: same samples with enable=0 for 3 cycles after the 3rd sample -> x_ready=0 during the stall and identical results. A following frame 10,20,30,40 -> (400,40), (100,0).
- Backpressure: out_ready=0 throughout, two frames sent -> x_ready drops at pos=3 of frame 2. Releasing out_ready gives frame 1 then frame 2, with the same-cycle handoff and no bubble after out_last.
- Resync: x=1,2 then x_sof with x=1, followed by 2,3,4 -> frame_err pulses exactly once and outputs are (40,4),(10,0).
- Overflow: bin0 w_re all 32767, x=32767 x4 -> re=-262140 without the macro, re=2147483647 with SYST_DFT_SAT_EN.
- Reset mid-drain: assert rst while bin_idx=1 -> next cycle out_valid=0, x_ready=enable. A fresh frame afterwards produces correct sums.
